// File: rtl/softlimiter_pwl_pkg.sv
// rtl/softlimiter_pwl_pkg.sv - shared mode encodings, gain format and curve-table helpers
package softlimiter_pwl_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HARD   = 2'd1,
    MODE_SOFT   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  localparam int GAIN_FRAC = 4;
  localparam int CURVE_K   = 2;

  function automatic int sig_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Series expansion keeps the table build free of math system calls.
  function automatic real exp_r(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 40; n++) begin
      term = term * x / real'(n);
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real tanh_r(input real x);
    real e2;
    e2 = exp_r(2.0 * x);
    return (e2 - 1.0) / (e2 + 1.0);
  endfunction

  function automatic int tanh_point(input int k, input int segs, input int maxv);
    real v;
    v = real'(maxv) * tanh_r(real'(CURVE_K * k) / real'(segs)) / tanh_r(real'(CURVE_K));
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/softlimiter_pwl_tanh_rom.sv
// rtl/softlimiter_pwl_tanh_rom.sv - dual-read tanh curve table with registered outputs
module tanh_rom
  import softlimiter_pwl_pkg::*;
#(
  parameter  int SIGWIDTH = 8,
  parameter  int SEGMENTS = 16,
  localparam int AW       = $clog2(SEGMENTS) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [AW-1:0]       addr_a,
  input  logic [AW-1:0]       addr_b,
  output logic [SIGWIDTH-1:0] data_a,
  output logic [SIGWIDTH-1:0] data_b
);

  logic [SIGWIDTH-1:0] lut [SEGMENTS+1];

  for (genvar k = 0; k <= SEGMENTS; k++) begin : g_lut
    localparam int POINT = tanh_point(k, SEGMENTS, sig_max(SIGWIDTH));
    assign lut[k] = SIGWIDTH'(POINT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= lut[addr_a];
      data_b <= lut[addr_b];
    end
  end

endmodule

// File: rtl/softlimiter_pwl.sv
// rtl/softlimiter_pwl.sv - pre-gain, clip/soft-limit pipeline with overdrive hold
module softlimiter_pwl
  import softlimiter_pwl_pkg::*;
#(
  parameter int SIGWIDTH  = 8,
  parameter int SEGMENTS  = 16,
  parameter int GAINWIDTH = 8,
  parameter int CLIPHOLD  = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sampleClk,
  input  logic [1:0]           mode,
  input  logic [GAINWIDTH-1:0] gain,
  input  logic [SIGWIDTH-1:0]  sampleIn,
  output logic [SIGWIDTH-1:0]  sampleOut,
  output logic                 sampleValid,
  output logic                 overdrive
);

  localparam int IW = $clog2(SEGMENTS);
  localparam int F  = SIGWIDTH - 1 - IW;
  localparam int PW = SIGWIDTH + GAINWIDTH + 1;
  localparam int CW = $clog2(CLIPHOLD + 1);
  localparam logic signed [PW-1:0]       P_MAX = PW'(sig_max(SIGWIDTH));
  localparam logic signed [PW-1:0]       P_MIN = ~P_MAX;
  localparam logic signed [SIGWIDTH-1:0] S_MAX = SIGWIDTH'(sig_max(SIGWIDTH));
  localparam logic signed [SIGWIDTH-1:0] S_MIN = ~S_MAX;

  // S1: gain and saturate
  logic signed [PW-1:0]       prod, shifted;
  logic                       s1_valid, s1_sat;
  mode_t                      s1_mode;
  logic signed [SIGWIDTH-1:0] s1_p;

  assign prod    = $signed(sampleIn) * $signed({1'b0, gain});
  assign shifted = prod >>> GAIN_FRAC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_mode  <= MODE_BYPASS;
      s1_p     <= '0;
    end else begin
      s1_valid <= sampleClk;
      if (sampleClk) begin
        s1_mode <= mode_t'(mode);
        if (mode_t'(mode) == MODE_BYPASS) begin
          s1_p   <= sampleIn;
          s1_sat <= 1'b0;
        end else if (shifted > P_MAX) begin
          s1_p   <= S_MAX;
          s1_sat <= 1'b1;
        end else if (shifted < P_MIN) begin
          s1_p   <= S_MIN;
          s1_sat <= 1'b1;
        end else begin
          s1_p   <= shifted[SIGWIDTH-1:0];
          s1_sat <= 1'b0;
        end
      end
    end
  end

  // S2: magnitude (MIN folds onto MAX) split into segment index and fraction
  logic [SIGWIDTH-2:0]        mag;
  logic                       s2_valid, s2_sat, s2_neg;
  mode_t                      s2_mode;
  logic signed [SIGWIDTH-1:0] s2_p;
  logic [IW-1:0]              s2_idx;
  logic [F-1:0]               s2_frac;

  always_comb begin
    mag = s1_p[SIGWIDTH-2:0];
    if (s1_p == S_MIN)          mag = '1;
    else if (s1_p[SIGWIDTH-1])  mag = (SIGWIDTH-1)'(-s1_p);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sat   <= 1'b0;
      s2_neg   <= 1'b0;
      s2_mode  <= MODE_BYPASS;
      s2_p     <= '0;
      s2_idx   <= '0;
      s2_frac  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sat  <= s1_sat;
        s2_neg  <= s1_p[SIGWIDTH-1];
        s2_mode <= s1_mode;
        s2_p    <= s1_p;
        s2_idx  <= mag[SIGWIDTH-2 -: IW];
        s2_frac <= mag[F-1:0];
      end
    end
  end

  // S3: table read, side-band carried alongside
  logic [IW:0]                rom_addr_a, rom_addr_b;
  logic [SIGWIDTH-1:0]        lut_a, lut_b;
  logic                       s3_valid, s3_sat, s3_neg;
  mode_t                      s3_mode;
  logic signed [SIGWIDTH-1:0] s3_p;
  logic [F-1:0]               s3_frac;

  assign rom_addr_a = {1'b0, s2_idx};
  assign rom_addr_b = rom_addr_a + 1'b1;

  tanh_rom #(.SIGWIDTH(SIGWIDTH), .SEGMENTS(SEGMENTS)) u_rom (
    .clk    (clk),
    .reset  (reset),
    .en     (s2_valid),
    .addr_a (rom_addr_a),
    .addr_b (rom_addr_b),
    .data_a (lut_a),
    .data_b (lut_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_sat   <= 1'b0;
      s3_neg   <= 1'b0;
      s3_mode  <= MODE_BYPASS;
      s3_p     <= '0;
      s3_frac  <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sat  <= s2_sat;
        s3_neg  <= s2_neg;
        s3_mode <= s2_mode;
        s3_p    <= s2_p;
        s3_frac <= s2_frac;
      end
    end
  end

  // S4: interpolate, restore sign, select by mode; overdrive hold counter
  logic [SIGWIDTH-1:0]   diff, y, result;
  logic [SIGWIDTH+F-1:0] step;
  logic [CW-1:0]         hold_cnt;

  assign diff = lut_b - lut_a;
  assign step = diff * s3_frac;
  assign y    = lut_a + SIGWIDTH'(step >> F);

  always_comb begin
    result = s3_neg ? -y : y;
    if (s3_mode == MODE_BYPASS || s3_mode == MODE_HARD) result = s3_p;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampleOut   <= '0;
      sampleValid <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      sampleValid <= s3_valid;
      if (s3_valid) begin
        sampleOut <= result;
        if (s3_sat)              hold_cnt <= CW'(CLIPHOLD);
        else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign overdrive = (hold_cnt != '0);

endmodule

// File: tb/tb_softlimiter_pwl.sv
// tb/tb_softlimiter_pwl.sv - self-checking bench for softlimiter_pwl
module tb_softlimiter_pwl;

  localparam int NOLIT = 9999;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sampleClk;
  logic [1:0] mode;
  logic [7:0] gain;
  logic [7:0] sampleIn;
  logic [7:0] sampleOut;
  logic       sampleValid;
  logic       overdrive;

  softlimiter_pwl #(.SIGWIDTH(8), .SEGMENTS(16), .GAINWIDTH(8), .CLIPHOLD(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .sampleClk   (sampleClk),
    .mode        (mode),
    .gain        (gain),
    .sampleIn    (sampleIn),
    .sampleOut   (sampleOut),
    .sampleValid (sampleValid),
    .overdrive   (overdrive)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int y;
    bit sat;
    int lit;
  } exp_t;

  exp_t q[$];
  int   rec_q[$];
  int   lut_m[17];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_out = 0;
  int   od_cnt   = 0;
  bit   checking = 0;
  bit   rec      = 0;
  bit   due_now;
  exp_t e_cur;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model(input int md, input int g, input int x, output int y, output bit sat);
    int p, a, k, fr;
    sat = 0;
    if (md == 0) p = x;
    else begin
      p = (x * g) >>> 4;
      if (p > 127) begin p = 127; sat = 1; end
      else if (p < -128) begin p = -128; sat = 1; end
    end
    if (md == 0 || md == 1) y = p;
    else begin
      a = (p < 0) ? -p : p;
      if (a > 127) a = 127;
      k  = a / 8;
      fr = a % 8;
      y  = lut_m[k] + ((lut_m[k+1] - lut_m[k]) * fr) / 8;
      if (p < 0) y = -y;
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (checking && !reset) begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      check("valid", int'(sampleValid), int'(due_now));
      if (due_now) begin
        e_cur = q.pop_front();
        check("out", $signed(sampleOut), e_cur.y);
        if (e_cur.lit != NOLIT) check("lit", $signed(sampleOut), e_cur.lit);
        last_out = e_cur.y;
        if (e_cur.sat) od_cnt = HOLD;
        else if (od_cnt > 0) od_cnt--;
        if (rec) rec_q.push_back($signed(sampleOut));
      end else begin
        check("hold", $signed(sampleOut), last_out);
      end
      check("overdrive", int'(overdrive), int'(od_cnt != 0));
    end
  end

  task automatic send(input int md, input int g, input int x, input int lit);
    int   y;
    bit   s;
    exp_t e;
    model(md, g, x, y, s);
    e.due = cyc + 4;
    e.y   = y;
    e.sat = s;
    e.lit = lit;
    q.push_back(e);
    mode      = md[1:0];
    gain      = g[7:0];
    sampleIn  = x[7:0];
    sampleClk = 1'b1;
    @(posedge clk); #1;
    sampleClk = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k <= 16; k++)
      lut_m[k] = $rtoi(127.0 * $tanh(2.0 * k / 16.0) / $tanh(2.0) + 0.5);

    reset = 1'b1; sampleClk = 1'b0; mode = 2'd0; gain = 8'h10; sampleIn = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", int'(sampleOut), 0);
    check("rst_valid", int'(sampleValid), 0);
    check("rst_od", int'(overdrive), 0);
    reset = 1'b0;
    checking = 1'b1;

    check("lut0", lut_m[0], 0);
    check("lut8", lut_m[8], 100);
    check("lut15", lut_m[15], 126);
    check("lut16", lut_m[16], 127);

    send(2, 'h10, 0, 0);
    send(2, 'h10, 64, 100);
    send(2, 'h10, -64, -100);
    drain();
    send(2, 'h10, 127, 126);
    send(2, 'h10, -128, -126);
    drain();
    check("od_soft", int'(overdrive), 0);

    send(1, 'h40, 50, 127);
    repeat (2) @(posedge clk);
    #1;
    send(1, 'h40, -50, -128);
    drain();
    check("od_set", int'(overdrive), 1);
    send(1, 'h10, 10, 10);
    send(1, 'h10, 20, 20);
    send(1, 'h10, -30, -30);
    drain();
    check("od_still", int'(overdrive), 1);
    send(1, 'h10, 40, 40);
    drain();
    check("od_drop", int'(overdrive), 0);

    send(0, 'h40, -77, -77);
    drain();
    check("od_bypass", int'(overdrive), 0);
    send(0, 'h40, 100, 100);
    send(2, 'h40, 100, 126);
    send(0, 'h40, -100, -100);
    send(2, 'h10, -100, -120);
    send(1, 'h40, 1, 4);
    drain();

    rec = 1'b1;
    for (int x = -128; x <= 127; x++) send(2, 'h10, x, NOLIT);
    drain();
    rec = 1'b0;
    check("ramp_count", rec_q.size(), 256);
    if (rec_q.size() == 256) begin
      for (int i = 1; i < 256; i++)
        if (rec_q[i] < rec_q[i-1]) check("ramp_mono", rec_q[i], rec_q[i-1]);
        else check("ramp_mono", 1, 1 * int'(rec_q[i] >= rec_q[i-1]));
      for (int x = 1; x <= 127; x++)
        check("ramp_odd", rec_q[128+x], -rec_q[128-x]);
    end

    send(1, 'h40, 60, 127);
    drain();
    send(2, 'h10, 64, NOLIT);
    send(2, 'h10, -64, NOLIT);
    send(1, 'h40, 90, NOLIT);
    checking = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("inflight_out", int'(sampleOut), 0);
    check("inflight_valid", int'(sampleValid), 0);
    check("inflight_od", int'(overdrive), 0);
    q.delete();
    od_cnt   = 0;
    last_out = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    checking = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(2, 'h10, 64, 100);
    drain();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
